divider_seq_ctrl: RTL and testbench

Sequencer that performs 4-bit unsigned restoring division by time-sharing one instance of the existing 4-bit ripple adder_subtractor, held permanently in subtract mode.
- One quotient bit is resolved per clock over 4 iteration cycles, behind a start/busy/done handshake.
- Sits beside the adder_subtractor in the arithmetic datapath, as the first multi-cycle user of that unit.

---
 rtl/divider_seq_ctrl_pkg.sv | 15 +
 rtl/adder_subtractor.sv | 24 ++
 rtl/divider_seq_ctrl.sv | 107 ++++++++++
 tb/tb_divider_seq_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/divider_seq_ctrl_pkg.sv
// Shared types and constants for the sequential divider controller.
package divider_seq_ctrl_pkg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 2;

    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : divider_seq_ctrl_pkg

// File: rtl/adder_subtractor.sv
// 4-bit ripple adder/subtractor: mode=0 gives a+b, mode=1 gives a-b (cout=1 means no borrow).
module adder_subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       mode,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] b_x;
    logic [4:0] c;

    assign b_x  = b ^ {4{mode}};
    assign c[0] = mode;

    // Ripple full-adder chain
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b_x[i] ^ c[i];
        assign c[i+1] = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
    end

    assign cout = c[4];

endmodule : adder_subtractor

// File: rtl/divider_seq_ctrl.sv
// Restoring 4-bit unsigned divider, one quotient bit per clock using a shared subtractor.
module divider_seq_ctrl
    import divider_seq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t             state_q;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   d_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   rs;
    logic               msb;
    logic [WIDTH-1:0]   diff;
    logic               no_borrow;
    logic               ge;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   q_d;

    // Shared subtractor permanently in subtract mode: diff = Rs - D
    adder_subtractor u_sub (
        .a    (rs),
        .b    (d_q),
        .mode (1'b1),
        .s    (diff),
        .cout (no_borrow)
    );

    // One restoring step; a shifted-out msb means the partial remainder is >= 16 > D
    always_comb begin
        rs  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        msb = r_q[WIDTH-1];
        ge  = msb | no_borrow;
        r_d = ge ? diff : rs;
        q_d = {q_q[WIDTH-2:0], ge};
    end

    // Controller FSM with iteration registers and registered results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            quotient    <= DBZ_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            q_q     <= dividend;
                            d_q     <= divisor;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quotient    <= q_d;
                        remainder   <= r_d;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : divider_seq_ctrl

// File: tb/tb_divider_seq_ctrl.sv
// Directed bench for the sequential divider controller.
module tb_divider_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int tests;
    int failed;
    int done_seen;
    int done_exp;

    divider_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse, sampled mid-cycle
    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request across one edge; optionally keep start and operands
    task automatic accept(input logic [3:0] dd, input logic [3:0] dv, input bit hold);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        step();
        if (!hold) begin
            start    = 1'b0;
            dividend = 4'($urandom);
            divisor  = 4'($urandom);
        end
    endtask

    // Wait (bounded) for done, check latency/results, then the return to IDLE
    task automatic wait_done(input string tag, input int exp_lat, input logic [3:0] eq,
                             input logic [3:0] er, input logic edbz);
        int lat;
        lat = 1;
        check({tag, "_busy"}, 8'(busy), 8'd1);
        while (done !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        done_exp++;
        check({tag, "_lat"}, 8'(lat), 8'(exp_lat));
        check({tag, "_q"}, 8'(quotient), 8'(eq));
        check({tag, "_r"}, 8'(remainder), 8'(er));
        check({tag, "_dbz"}, 8'(div_by_zero), 8'(edbz));
        step();
        check({tag, "_done_1cyc"}, 8'({busy, done}), 8'd0);
        check({tag, "_q_hold"}, 8'(quotient), 8'(eq));
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        done_seen = 0;
        done_exp  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 4'd0;
        divisor   = 4'd0;

        step();
        step();
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_q", 8'(quotient), 8'd0);
        check("rst_r", 8'(remainder), 8'd0);
        check("rst_dbz", 8'(div_by_zero), 8'd0);
        rst_n = 1'b1;
        step();

        accept(4'd13, 4'd3, 1'b0);
        wait_done("d13_3", 5, 4'd4, 4'd1, 1'b0);
        accept(4'd15, 4'd8, 1'b0);
        wait_done("d15_8", 5, 4'd1, 4'd7, 1'b0);
        accept(4'd15, 4'd1, 1'b0);
        wait_done("d15_1", 5, 4'd15, 4'd0, 1'b0);
        accept(4'd3, 4'd7, 1'b0);
        wait_done("d3_7", 5, 4'd0, 4'd3, 1'b0);
        accept(4'd9, 4'd0, 1'b0);
        wait_done("d9_0", 1, 4'hF, 4'd9, 1'b1);
        accept(4'd6, 4'd2, 1'b0);
        wait_done("d6_2", 5, 4'd3, 4'd0, 1'b0);

        // Busy rejection: start held high, operands changed after accept
        accept(4'd13, 4'd3, 1'b1);
        dividend = 4'd8;
        divisor  = 4'd2;
        wait_done("hold13_3", 5, 4'd4, 4'd1, 1'b0);
        step();
        start = 1'b0;
        check("hold_reaccept_busy", 8'(busy), 8'd1);
        wait_done("hold8_2", 5, 4'd4, 4'd0, 1'b0);

        // Reset abort in the 2nd RUN cycle
        accept(4'd13, 4'd3, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        check("abort_q", 8'(quotient), 8'd0);
        check("abort_r", 8'(remainder), 8'd0);
        check("abort_dbz", 8'(div_by_zero), 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_done", 8'(done), 8'd0);
        end
        accept(4'd10, 4'd4, 1'b0);
        wait_done("d10_4", 5, 4'd2, 4'd2, 1'b0);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                accept(4'(a), 4'(b), 1'b0);
                if (b == 0)
                    wait_done("sweep_dbz", 1, 4'hF, 4'(a), 1'b1);
                else
                    wait_done("sweep", 5, 4'(a / b), 4'(a % b), 1'b0);
            end
        end

        step();
        check("done_count", 8'(done_seen), 8'(done_exp));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_divider_seq_ctrl
